// File: rtl/debounce_edge.sv
// Debounces one raw asynchronous input into a clean registered level plus
// single-cycle rise/fall pulses that downstream registers use as enables.
module debounce_edge #(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8,
  parameter int STABLE_CYCLES = 200
) (
  input  logic clk,
  input  logic res_n,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {LO, WAIT_HI, HI, WAIT_LO} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  state_t                 r_state;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  logic                   w_s;
  logic                   w_atLast;
  state_t                 w_stateNext;
  logic [CNT_W-1:0]       w_cntNext;
  logic                   w_levelNext;
  logic                   w_riseNext;
  logic                   w_fallNext;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_atLast = (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_state <= LO;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], btn_in};
      r_cnt   <= w_cntNext;
      r_state <= w_stateNext;
      r_level <= w_levelNext;
      r_rise  <= w_riseNext;
      r_fall  <= w_fallNext;
    end
  end

  // The counter restarts from zero on every entry to a WAIT state, so a
  // glitch never carries partial credit into the next attempt.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      LO: begin
        if (w_s) begin
          w_stateNext = WAIT_HI;
          w_cntNext   = '0;
        end
      end
      WAIT_HI: begin
        if (!w_s) begin
          w_stateNext = LO;
          w_cntNext   = '0;
        end else if (w_atLast) begin
          w_stateNext = HI;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      HI: begin
        if (!w_s) begin
          w_stateNext = WAIT_LO;
          w_cntNext   = '0;
        end
      end
      WAIT_LO: begin
        if (w_s) begin
          w_stateNext = HI;
          w_cntNext   = '0;
        end else if (w_atLast) begin
          w_stateNext = LO;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_stateNext = LO;
        w_cntNext   = '0;
      end
    endcase
  end

  always_comb begin
    w_riseNext  = (r_state == WAIT_HI) && w_s && w_atLast;
    w_fallNext  = (r_state == WAIT_LO) && !w_s && w_atLast;
    w_levelNext = r_level;
    if (w_riseNext) begin
      w_levelNext = 1'b1;
    end else if (w_fallNext) begin
      w_levelNext = 1'b0;
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule
